// File: rtl/pe_pkg.sv
// Shared definitions for the CGRA processing element: ALU opcodes, crossbar
// source encodings and the bit layout of the serial configuration word.
package pe_pkg;

  localparam int CFG_W        = 13;
  localparam int ALU_OP_MSB   = 12;
  localparam int ALU_OP_LSB   = 9;
  localparam int OUT_SEL_BIT  = 8;
  localparam int SEL_W        = 2;
  localparam int NUM_XBAR     = 4;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_SLL  = 4'd6,
    OP_SRL  = 4'd7,
    OP_SRA  = 4'd8,
    OP_SLT  = 4'd9,
    OP_EQ   = 4'd10,
    OP_PASA = 4'd11,
    OP_PASB = 4'd12,
    OP_NOT  = 4'd13,
    OP_MIN  = 4'd14,
    OP_MAX  = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC_IN0 = 2'd0,
    SRC_IN1 = 2'd1,
    SRC_ALU = 2'd2,
    SRC_MEM = 2'd3
  } src_e;

  // Crossbar output k takes its select from cfg[2k+1:2k].
  function automatic int sel_lsb(input int k);
    return k * SEL_W;
  endfunction

endpackage

// File: rtl/pe_alu_switch_if.sv
// Data and scan-chain signals of one PE; the PE itself connects through the
// slave modport, the surrounding wrapper (or bench) through master.
interface pe_alu_switch_if #(
  parameter int size = 32
);

  logic            config_en;
  logic            config_in;
  logic            config_out;
  logic [size-1:0] in0;
  logic [size-1:0] in1;
  logic [size-1:0] mem_in;
  logic [size-1:0] mem_a;
  logic [size-1:0] mem_b;
  logic [size-1:0] alu_out;
  logic [size-1:0] out0;

  modport slave (
    input  config_en, config_in, in0, in1, mem_in,
    output config_out, mem_a, mem_b, alu_out, out0
  );

  modport master (
    output config_en, config_in, in0, in1, mem_in,
    input  config_out, mem_a, mem_b, alu_out, out0
  );

endinterface

// File: rtl/pe_alu.sv
// Purely combinational ALU of the PE; the result is registered by the caller.
module pe_alu
  import pe_pkg::*;
#(
  parameter int size = 32
) (
  input  alu_op_e         alu_op,
  input  logic [size-1:0] a,
  input  logic [size-1:0] b,
  output logic [size-1:0] result
);

  localparam int SHAMT_W = $clog2(size);

  logic [SHAMT_W-1:0] shamt;
  logic               a_lt_b;

  assign shamt  = b[SHAMT_W-1:0];
  assign a_lt_b = $signed(a) < $signed(b);

  // Comparison results are zero-extended single bits; all others truncate.
  always_comb begin
    result = '0;
    case (alu_op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_MUL:  result = a * b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLL:  result = a << shamt;
      OP_SRL:  result = a >> shamt;
      OP_SRA:  result = $unsigned($signed(a) >>> shamt);
      OP_SLT:  result = {{(size-1){1'b0}}, a_lt_b};
      OP_EQ:   result = {{(size-1){1'b0}}, (a == b)};
      OP_PASA: result = a;
      OP_PASB: result = b;
      OP_NOT:  result = ~a;
      OP_MIN:  result = a_lt_b ? a : b;
      OP_MAX:  result = a_lt_b ? b : a;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/pe_alu_switch.sv
// CGRA PE datapath: scan-loaded config, 4x4 input crossbar, registered ALU
// and a 2:1 output switch between the ALU and the external memory result.
module pe_alu_switch
  import pe_pkg::*;
#(
  parameter int size = 32
) (
  input  logic            clk,
  input  logic            reset,
  pe_alu_switch_if.slave  bus
);

  logic [CFG_W-1:0] cfg;
  alu_op_e          alu_op;
  logic             out_sel;
  src_e             sel    [NUM_XBAR];
  logic [size-1:0]  src    [NUM_XBAR];
  logic [size-1:0]  xbar   [NUM_XBAR];
  logic [size-1:0]  alu_next;
  logic [size-1:0]  alu_q;

  // Scan chain shifts MSB-first so the first bit in ends up at cfg[12].
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg <= '0;
    end else if (bus.config_en) begin
      cfg <= {cfg[CFG_W-2:0], bus.config_in};
    end
  end

  assign bus.config_out = cfg[CFG_W-1];
  assign alu_op         = alu_op_e'(cfg[ALU_OP_MSB:ALU_OP_LSB]);
  assign out_sel        = cfg[OUT_SEL_BIT];

  assign src[SRC_IN0] = bus.in0;
  assign src[SRC_IN1] = bus.in1;
  assign src[SRC_ALU] = alu_q;
  assign src[SRC_MEM] = bus.mem_in;

  for (genvar k = 0; k < NUM_XBAR; k++) begin : g_xbar
    assign sel[k]  = src_e'(cfg[sel_lsb(k) +: SEL_W]);
    assign xbar[k] = src[sel[k]];
  end

  pe_alu #(
    .size (size)
  ) u_alu (
    .alu_op (alu_op),
    .a      (xbar[0]),
    .b      (xbar[1]),
    .result (alu_next)
  );

  // The ALU register is what breaks the alu_out -> crossbar -> ALU loop.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_q <= '0;
    end else begin
      alu_q <= alu_next;
    end
  end

  assign bus.alu_out = alu_q;
  assign bus.mem_a   = xbar[2];
  assign bus.mem_b   = xbar[3];
  assign bus.out0    = out_sel ? bus.mem_in : alu_q;

endmodule

// File: tb/tb_pe_alu_switch.sv
// Self-checking bench for pe_alu_switch: fixed vectors, directed corner
// sequences and a randomized run against a cycle-level reference model.
module tb_pe_alu_switch;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [12:0] mcfg;
  logic [31:0] malu;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expected;
  } vec_t;

  vec_t vecs[16];

  pe_alu_switch_if #(.size(32)) bus ();

  pe_alu_switch #(.size(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] mkCfg(input logic [3:0] op, input logic osel,
                                        input logic [1:0] s3, input logic [1:0] s2,
                                        input logic [1:0] s1, input logic [1:0] s0);
    return {op, osel, s3, s2, s1, s0};
  endfunction

  function automatic logic [31:0] refAlu(input int op, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a * b;
      3:  return a & b;
      4:  return a | b;
      5:  return a ^ b;
      6:  return a << b[4:0];
      7:  return a >> b[4:0];
      8:  return sa >>> b[4:0];
      9:  return (sa < sb) ? 32'd1 : 32'd0;
      10: return (a == b) ? 32'd1 : 32'd0;
      11: return a;
      12: return b;
      13: return ~a;
      14: return (sa < sb) ? a : b;
      default: return (sa < sb) ? b : a;
    endcase
  endfunction

  function automatic logic [31:0] refSrc(input logic [1:0] s);
    case (s)
      2'd0:    return bus.in0;
      2'd1:    return bus.in1;
      2'd2:    return malu;
      default: return bus.mem_in;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, " alu_out"}, bus.alu_out, malu);
    checkOutput({tag, " out0"}, bus.out0, mcfg[8] ? bus.mem_in : malu);
    checkOutput({tag, " mem_a"}, bus.mem_a, refSrc(mcfg[5:4]));
    checkOutput({tag, " mem_b"}, bus.mem_b, refSrc(mcfg[7:6]));
    checkOutput({tag, " config_out"}, {31'd0, bus.config_out}, {31'd0, mcfg[12]});
  endtask

  // One clock: the model takes its next state from the inputs as they stand
  // just before the edge, then outputs are sampled 1 time unit after it.
  task automatic tick();
    logic [12:0] ncfg;
    logic [31:0] nalu;
    if (reset) begin
      ncfg = '0;
      nalu = '0;
    end else begin
      ncfg = bus.config_en ? {mcfg[11:0], bus.config_in} : mcfg;
      nalu = refAlu(int'(mcfg[12:9]), refSrc(mcfg[1:0]), refSrc(mcfg[3:2]));
    end
    @(posedge clk);
    mcfg = ncfg;
    malu = nalu;
    #1;
  endtask

  task automatic loadConfig(input logic [12:0] v);
    bus.config_en = 1'b1;
    for (int i = 12; i >= 0; i--) begin
      bus.config_in = v[i];
      tick();
      checkAll("load");
    end
    bus.config_en = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] mi);
    bus.in0    = i0;
    bus.in1    = i1;
    bus.mem_in = mi;
  endtask

  initial begin
    logic [31:0] holdA;
    logic [31:0] holdB;
    logic [31:0] holdO;

    vecs[0]  = '{4'd0,  32'd5,          32'd7,          32'd12};
    vecs[1]  = '{4'd1,  32'd0,          32'd1,          32'hFFFF_FFFF};
    vecs[2]  = '{4'd2,  32'h0001_0000,  32'h0001_0000,  32'h0};
    vecs[3]  = '{4'd3,  32'hF0,         32'h3C,         32'h30};
    vecs[4]  = '{4'd4,  32'hF0,         32'h3C,         32'hFC};
    vecs[5]  = '{4'd5,  32'hF0,         32'h3C,         32'hCC};
    vecs[6]  = '{4'd6,  32'd1,          32'd31,         32'h8000_0000};
    vecs[7]  = '{4'd7,  32'h8000_0000,  32'd31,         32'd1};
    vecs[8]  = '{4'd8,  32'h8000_0000,  32'd4,          32'hF800_0000};
    vecs[9]  = '{4'd9,  32'hFFFF_FFFF,  32'd1,          32'd1};
    vecs[10] = '{4'd10, 32'd5,          32'd5,          32'd1};
    vecs[11] = '{4'd11, 32'd3,          32'd9,          32'd3};
    vecs[12] = '{4'd12, 32'd3,          32'd9,          32'd9};
    vecs[13] = '{4'd13, 32'd0,          32'd9,          32'hFFFF_FFFF};
    vecs[14] = '{4'd14, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF};
    vecs[15] = '{4'd15, 32'hFFFF_FFFF,  32'd1,          32'd1};

    mcfg = '0;
    malu = '0;
    reset = 1'b1;
    bus.config_en = 1'b0;
    bus.config_in = 1'b0;
    applyStimulus(32'd0, 32'd0, 32'd0);
    tick();
    checkOutput("reset alu_out", bus.alu_out, 32'd0);
    checkOutput("reset out0", bus.out0, 32'd0);
    checkOutput("reset config_out", {31'd0, bus.config_out}, 32'd0);
    reset = 1'b0;

    // ADD with sel1=in1, then a marker pattern to watch bits reach config_out.
    applyStimulus(32'd5, 32'd7, 32'd0);
    loadConfig(13'b0000_0_00_00_01_00);
    tick();
    checkOutput("first add alu_out", bus.alu_out, 32'd12);
    checkOutput("first add out0", bus.out0, 32'd12);
    loadConfig(13'b1010_0_00_00_01_00);
    checkOutput("marker config_out", {31'd0, bus.config_out}, 32'd1);

    foreach (vecs[i]) begin
      loadConfig(mkCfg(vecs[i].op, 1'b0, 2'd0, 2'd0, 2'd1, 2'd0));
      applyStimulus(vecs[i].a, vecs[i].b, 32'h1234);
      tick();
      checkOutput($sformatf("vec%0d alu_out", i), bus.alu_out, vecs[i].expected);
      checkAll("vec");
    end

    // Accumulate through the alu_out feedback path starting from zero.
    reset = 1'b1;
    applyStimulus(32'd0, 32'd0, 32'd0);
    tick();
    reset = 1'b0;
    loadConfig(mkCfg(4'd0, 1'b0, 2'd0, 2'd0, 2'd1, 2'd2));
    checkOutput("acc start", bus.alu_out, 32'd0);
    applyStimulus(32'd0, 32'd3, 32'd0);
    for (int n = 1; n <= 3; n++) begin
      tick();
      checkOutput($sformatf("acc step%0d", n), bus.alu_out, 32'(3 * n));
    end

    // Synchronous reset: nothing changes until the edge, config_en ignored.
    reset = 1'b1;
    bus.config_en = 1'b1;
    bus.config_in = 1'b1;
    #1;
    checkOutput("pre-reset alu_out", bus.alu_out, 32'd9);
    tick();
    checkOutput("sync reset alu_out", bus.alu_out, 32'd0);
    checkOutput("sync reset config_out", {31'd0, bus.config_out}, 32'd0);
    reset = 1'b0;
    bus.config_en = 1'b0;
    applyStimulus(32'h77, 32'h11, 32'h22);
    #1;
    checkOutput("post-reset mem_a", bus.mem_a, 32'h77);
    checkOutput("post-reset mem_b", bus.mem_b, 32'h77);

    // Memory routing and output switch, checked without a clock edge.
    loadConfig(mkCfg(4'd0, 1'b1, 2'd3, 2'd1, 2'd0, 2'd0));
    applyStimulus(32'h1, 32'hAA, 32'h55);
    #1;
    checkOutput("route mem_a", bus.mem_a, 32'hAA);
    checkOutput("route mem_b", bus.mem_b, 32'h55);
    checkOutput("route out0", bus.out0, 32'h55);

    // Hold: toggling config_in without config_en must not move the config.
    holdA = bus.mem_a;
    holdB = bus.mem_b;
    holdO = bus.out0;
    for (int n = 0; n < 20; n++) begin
      bus.config_in = n[0];
      tick();
      checkOutput("hold mem_a", bus.mem_a, 32'hAA);
      checkOutput("hold mem_b", bus.mem_b, 32'h55);
      checkOutput("hold out0", bus.out0, 32'h55);
      checkAll("hold");
    end
    checkOutput("hold stable", bus.mem_a ^ bus.mem_b ^ bus.out0, holdA ^ holdB ^ holdO);

    // Randomized configurations and data against the reference model.
    for (int r = 0; r < 30; r++) begin
      applyStimulus($urandom, $urandom, $urandom);
      loadConfig(13'($urandom));
      for (int c = 0; c < 6; c++) begin
        applyStimulus($urandom, (c % 2 == 0) ? 32'($urandom_range(0, 40)) : $urandom, $urandom);
        reset = ($urandom_range(0, 24) == 0);
        bus.config_en = ($urandom_range(0, 5) == 0);
        bus.config_in = 1'($urandom);
        tick();
        checkAll("rand");
      end
      reset = 1'b0;
      bus.config_en = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pe_alu_switch.md
Name: pe_alu_switch

Overview:
- Configurable PE datapath for the CGRA tile: a 4x4 input crossbar feeds a registered 32-bit ALU and two memory-operand ports, and a 2:1 output switch selects the ALU or memory result.
- Configuration bits are loaded through a serial scan chain in the same clock domain.
- Sits inside a PE wrapper. The memory unit is external: its operands leave on mem_a/mem_b and its result returns on mem_in.

Parameters:
- size, 32, datapath width of all data ports.
- CFG_W, 13, scan-chain length (localparam; fixed by field layout).

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears config chain and ALU register.
- config_en  input  1  when high, scan chain shifts one bit per clk.
- config_in  input  1  serial config data in.
- config_out  output  1  serial config data out (cfg[12]); for daisy-chaining.
- in0  input  size  PE data input 0 (crossbar source 0).
- in1  input  size  PE data input 1 (crossbar source 1).
- mem_in  input  size  external memory result (crossbar source 3, output-switch source 1).
- mem_a  output  size  crossbar output 2 (memory operand 0).
- mem_b  output  size  crossbar output 3 (memory operand 1).
- alu_out  output  size  registered ALU result (crossbar source 2, output-switch source 0).
- out0  output  size  PE result from the output switch.

Behaviour:
- Config register cfg[12:0]:
  - On reset: all zeros. Reset has priority over config_en.
  - Else, if config_en: cfg <= {cfg[11:0], config_in}.
  - Else: hold.
  - config_out = cfg[12], combinational from the register.
  - Loading 13 bits MSB-first puts the first bit shifted in at cfg[12].
- Field layout:
  - cfg[12:9] alu_op.
  - cfg[8] out_sel.
  - cfg[7:6] sel3, cfg[5:4] sel2, cfg[3:2] sel1, cfg[1:0] sel0.
- Crossbar (combinational): xbar_k = source[sel_k], with sources 0=in0, 1=in1, 2=alu_out, 3=mem_in. All four outputs are independent; any source may drive several outputs at once.
- Operands and memory ports: ALU operand a = xbar0, b = xbar1; mem_a = xbar2; mem_b = xbar3.
- ALU register: on reset, alu_out <= 0; otherwise every clk, alu_out <= f(alu_op, a, b). Latency is one cycle from operand to alu_out. The register breaks the alu_out→crossbar loop. No combinational path from alu_out back to itself.
- ALU opcodes (results truncated to size bits):
  - 0 a+b (wraps)
  - 1 a-b (wraps)
  - 2 a*b low half
  - 3 a&b
  - 4 a|b
  - 5 a^b
  - 6 a<<b[4:0]
  - 7 a>>b[4:0] logical
  - 8 a>>>b[4:0] arithmetic
  - 9 signed a<b ? 1 : 0
  - 10 a==b ? 1 : 0
  - 11 a
  - 12 b
  - 13 ~a
  - 14 signed min
  - 15 signed max
- Output switch (combinational): out0 = out_sel ? mem_in : alu_out.
- Config changes mid-operation:
  - Shifting alters cfg fields every cycle, so datapath routing follows intermediate patterns during a load; system software ignores outputs while config_en is high.
  - The ALU keeps computing during shifting.
- After reset (cfg = 0), the block is in the following state:
  - alu_op = ADD; all crossbar selects = in0, so a = b = in0 and mem_a = mem_b = in0.
  - out0 = alu_out = 0 until the first clk after reset deasserts.

Decomposition:
- Shared package pe_pkg holds:
  - ALU opcode enum/localparams (OP_ADD..OP_MAX).
  - Crossbar source encodings (SRC_IN0, SRC_IN1, SRC_ALU, SRC_MEM).
  - cfg field bit positions and CFG_W.
- One natural sub-module: pe_alu (combinational function f plus opcode decode). The crossbar, output switch and config register stay in the top.

Test Plan:
- Reset then shift 13 bits 0b0000_0_00_00_01_00 (ADD, sel1=in1, others in0, out_sel=0); in0=5, in1=7 → one clk later alu_out=12, out0=12; config_out then shows the shifted-in bits 13 cycles after entry.
- SUB wrap: alu_op=1, in0=0, in1=1 → alu_out=32'hFFFF_FFFF after 1 clk. MUL: in0=32'h10000, in1=32'h10000 → 0. SRA: in0=32'h8000_0000, in1=4 → 32'hF800_0000. SLT: in0=32'hFFFF_FFFF, in1=1 → 1.
- Feedback accumulate: ADD, sel0=alu_out, sel1=in1, in1=3 from alu_out=0 → alu_out sequence 3, 6, 9 on successive clks.
- Memory routing: sel2=in1, sel3=mem_in, out_sel=1, in1=0xAA, mem_in=0x55 → mem_a=0xAA, mem_b=0x55, out0=0x55 combinationally.
- Synchronous reset mid-operation: with alu_out=9 and valid config, assert reset for one clk → alu_out=0, cfg=0, config_out=0 at that edge (not before). config_en high during reset → no shift.
- Hold: config_en low for 20 clks with toggling config_in → cfg unchanged, routing and outputs stable.
